// File: rtl/omem_write_scheduler.sv
// omem_write_scheduler
//   Shares the single output-memory Wishbone master port among NUM_CORES
//   execution cores. Each core posts a 96-bit row plus a base address; the
//   scheduler picks one round-robin, writes the row as three consecutive
//   Wishbone classic write cycles (base, base+1, base+2) and pulses oAck to
//   the owner. A word that is not acknowledged within ACK_TIMEOUT+1 strobe
//   cycles ends the transfer early with oError pulsed alongside oAck.
//
// Ports
//   CLK_I, RST_I        clock, synchronous active-high reset
//   iReq[N]             core i has a row posted (held until oAck[i])
//   iAddress[N*W]       per-core base address, core i at slice i
//   iData[N*ROW]        per-core row, core i at slice i
//   oAck[N]             one-cycle completion pulse to the granted core
//   oError              one-cycle pulse with oAck when the transfer timed out
//   OMEM_*              Wishbone classic master (write-only)
module omem_write_scheduler #(
    parameter int NUM_CORES   = 4,
    parameter int WB_WIDTH    = 32,
    parameter int ROW_WIDTH   = 96,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                           CLK_I,
    input  logic                           RST_I,
    input  logic [NUM_CORES-1:0]           iReq,
    input  logic [NUM_CORES*WB_WIDTH-1:0]  iAddress,
    input  logic [NUM_CORES*ROW_WIDTH-1:0] iData,
    output logic [NUM_CORES-1:0]           oAck,
    output logic                           oError,
    output logic [WB_WIDTH-1:0]            OMEM_ADR_O,
    output logic [WB_WIDTH-1:0]            OMEM_DAT_O,
    output logic                           OMEM_WE_O,
    output logic                           OMEM_STB_O,
    output logic                           OMEM_CYC_O,
    input  logic                           OMEM_ACK_I
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]     grant, grant_nxt;
    logic [1:0]           word, word_nxt;
    logic [1:0]           word_inc;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [NUM_CORES-1:0] ack_nxt;
    logic                 err_nxt;
    logic [WB_WIDTH-1:0]  adr_nxt, dat_nxt;
    logic                 stb_q, stb_nxt;
    logic                 load;

    logic [WB_WIDTH-1:0]  base_q;
    logic [ROW_WIDTH-1:0] row_q;

    logic                 req_found;
    logic [PTR_W-1:0]     req_idx;
    logic [PTR_W-1:0]     scan_idx;
    logic [WB_WIDTH-1:0]  sel_base;
    logic [ROW_WIDTH-1:0] sel_row;

    // Word 0 is the most significant component of the row.
    function automatic logic [WB_WIDTH-1:0] row_word(input logic [ROW_WIDTH-1:0] row,
                                                     input logic [1:0]           w);
        case (w)
            2'd0:    return row[ROW_WIDTH-1 -: WB_WIDTH];
            2'd1:    return row[2*WB_WIDTH-1 -: WB_WIDTH];
            default: return row[WB_WIDTH-1:0];
        endcase
    endfunction

    // Round-robin pick: scan downward over the offsets so the smallest
    // offset from rr_ptr that is requesting is the one left standing.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        scan_idx  = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_CORES);
            if (iReq[scan_idx]) begin
                req_found = 1'b1;
                req_idx   = scan_idx;
            end
        end
    end

    assign sel_base = iAddress[req_idx*WB_WIDTH +: WB_WIDTH];
    assign sel_row  = iData[req_idx*ROW_WIDTH +: ROW_WIDTH];
    assign word_inc = word + 2'd1;

    // Next-state and next-output logic; every bus output is registered from
    // these values so the bus sees them one cycle after the decision.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant;
        word_nxt   = word;
        cnt_nxt    = cnt;
        ack_nxt    = '0;
        err_nxt    = 1'b0;
        adr_nxt    = OMEM_ADR_O;
        dat_nxt    = OMEM_DAT_O;
        stb_nxt    = 1'b0;
        load       = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_found) begin
                    load      = 1'b1;
                    grant_nxt = req_idx;
                    word_nxt  = 2'd0;
                    cnt_nxt   = '0;
                    adr_nxt   = sel_base;
                    dat_nxt   = row_word(sel_row, 2'd0);
                    stb_nxt   = 1'b1;
                    state_nxt = S_WRITE;
                end
            end

            S_WRITE: begin
                stb_nxt = 1'b1;
                if (OMEM_ACK_I) begin
                    if (word != 2'd2) begin
                        // Next word goes out back-to-back with no idle strobe gap.
                        word_nxt = word_inc;
                        cnt_nxt  = '0;
                        adr_nxt  = base_q + WB_WIDTH'(word_inc);
                        dat_nxt  = row_word(row_q, word_inc);
                    end else begin
                        stb_nxt        = 1'b0;
                        ack_nxt[grant] = 1'b1;
                        state_nxt      = S_DONE;
                    end
                end else if (cnt == CNT_W'(ACK_TIMEOUT)) begin
                    // Counter has covered ACK_TIMEOUT+1 strobe cycles on this word.
                    stb_nxt        = 1'b0;
                    ack_nxt[grant] = 1'b1;
                    err_nxt        = 1'b1;
                    state_nxt      = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_DONE: begin
                rr_ptr_nxt = (int'(grant) == NUM_CORES - 1) ? '0 : grant + 1'b1;
                state_nxt  = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            word       <= 2'd0;
            cnt        <= '0;
            oAck       <= '0;
            oError     <= 1'b0;
            OMEM_ADR_O <= '0;
            OMEM_DAT_O <= '0;
            stb_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            grant      <= grant_nxt;
            word       <= word_nxt;
            cnt        <= cnt_nxt;
            oAck       <= ack_nxt;
            oError     <= err_nxt;
            OMEM_ADR_O <= adr_nxt;
            OMEM_DAT_O <= dat_nxt;
            stb_q      <= stb_nxt;
        end
    end

    // Row snapshot taken at grant; later changes on iData/iAddress are ignored.
    always_ff @(posedge CLK_I) begin
        if (load) begin
            base_q <= sel_base;
            row_q  <= sel_row;
        end
    end

    // The transfer never idles the strobe mid-row, so CYC and WE track STB.
    assign OMEM_STB_O = stb_q;
    assign OMEM_CYC_O = stb_q;
    assign OMEM_WE_O  = stb_q;

endmodule

// File: tb/tb_omem_write_scheduler.sv
module tb_omem_write_scheduler;

    localparam int N  = 4;
    localparam int TO = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   iReq;
    logic [N*32-1:0] iAddress;
    logic [N*96-1:0] iData;
    logic [N-1:0]   oAck;
    logic           oError;
    logic [31:0]    adr, dat;
    logic           we, stb, cyc, wb_ack;

    omem_write_scheduler #(
        .NUM_CORES(N), .WB_WIDTH(32), .ROW_WIDTH(96), .ACK_TIMEOUT(TO)
    ) dut (
        .CLK_I(clk), .RST_I(rst), .iReq(iReq), .iAddress(iAddress), .iData(iData),
        .oAck(oAck), .oError(oError), .OMEM_ADR_O(adr), .OMEM_DAT_O(dat),
        .OMEM_WE_O(we), .OMEM_STB_O(stb), .OMEM_CYC_O(cyc), .OMEM_ACK_I(wb_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    // slave / requester behaviour
    int     waits = 0;
    bit     never = 0;
    bit     spurious = 0;
    int     wcnt = 0;
    int     stb_cycles = 0;
    int     stray_err = 0;
    bit     auto_drop = 1;
    logic [N-1:0] drop_next = '0;

    // observed
    logic [31:0] wr_adr_q[$], wr_dat_q[$];
    int          wr_cyc_q[$];
    logic [N-1:0] ak_core_q[$];
    logic        ak_err_q[$];
    int          ak_cyc_q[$];
    // expected
    logic [31:0] ex_adr_q[$], ex_dat_q[$];
    int          ex_wcyc_q[$];
    logic [N-1:0] ex_core_q[$];
    logic        ex_err_q[$];
    int          ex_acyc_q[$];

    logic [31:0] base_t[N];
    logic [95:0] row_t[N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: slave decides ACK just after the edge, bus is observed at negedge.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (drop_next[i]) begin
                iReq[i]      = 1'b0;
                drop_next[i] = 1'b0;
            end
        wb_ack = spurious ? 1'b1 : (stb && !never && (wcnt >= waits));
        @(negedge clk);
        cyc_n++;
        check("cyc_we_follow_stb", {62'd0, cyc, we}, {62'd0, stb, stb});
        if (stb) stb_cycles++;
        if (stb && wb_ack) begin
            wr_adr_q.push_back(adr);
            wr_dat_q.push_back(dat);
            wr_cyc_q.push_back(cyc_n);
            wcnt = 0;
        end else if (stb) wcnt++;
        else wcnt = 0;
        if (oAck != '0) begin
            ak_core_q.push_back(oAck);
            ak_err_q.push_back(oError);
            ak_cyc_q.push_back(cyc_n);
            if (auto_drop) drop_next = drop_next | oAck;
        end
        if (oError && oAck == '0) stray_err++;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int start;
        start = cyc_n;
        while (ak_core_q.size() < n && (cyc_n - start) < budget) cycle();
        check("acks_arrived", ak_core_q.size(), n);
    endtask

    // Reference: a granted row becomes nw writes at base+k with word k taken
    // from the top of the row; with w wait states each word needs w+1 strobe
    // cycles, and the completion pulse follows the last word by one cycle.
    task automatic expect_xfer(input int core, input int t, input int w, input int nw,
                               input bit err, output int ack_cyc);
        logic [95:0] r;
        r = row_t[core];
        for (int k = 0; k < nw; k++) begin
            ex_adr_q.push_back(base_t[core] + 32'(k));
            ex_dat_q.push_back(r[95 - 32*k -: 32]);
            ex_wcyc_q.push_back(t + (k + 1) * (w + 1));
        end
        ack_cyc = t + 3 * (w + 1) + 1;
        if (nw == 3 || err) begin
            if (err) ack_cyc = t + TO + 2;
            ex_core_q.push_back(N'(1) << core);
            ex_err_q.push_back(err);
            ex_acyc_q.push_back(ack_cyc);
        end
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s_nwrites", tag), wr_adr_q.size(), ex_adr_q.size());
        for (int k = 0; k < wr_adr_q.size() && k < ex_adr_q.size(); k++) begin
            check($sformatf("%s_adr%0d", tag, k), wr_adr_q[k], ex_adr_q[k]);
            check($sformatf("%s_dat%0d", tag, k), wr_dat_q[k], ex_dat_q[k]);
            check($sformatf("%s_wcyc%0d", tag, k), wr_cyc_q[k], ex_wcyc_q[k]);
        end
        check($sformatf("%s_nacks", tag), ak_core_q.size(), ex_core_q.size());
        for (int k = 0; k < ak_core_q.size() && k < ex_core_q.size(); k++) begin
            check($sformatf("%s_ackcore%0d", tag, k), ak_core_q[k], ex_core_q[k]);
            check($sformatf("%s_ackerr%0d", tag, k), ak_err_q[k], ex_err_q[k]);
            check($sformatf("%s_ackcyc%0d", tag, k), ak_cyc_q[k], ex_acyc_q[k]);
        end
        wr_adr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
        ak_core_q.delete(); ak_err_q.delete(); ak_cyc_q.delete();
        ex_adr_q.delete(); ex_dat_q.delete(); ex_wcyc_q.delete();
        ex_core_q.delete(); ex_err_q.delete(); ex_acyc_q.delete();
    endtask

    task automatic post(input int core, input logic [31:0] base, input logic [95:0] row);
        base_t[core] = base;
        row_t[core]  = row;
        iAddress[core*32 +: 32] = base;
        iData[core*96 +: 96]    = row;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iReq = '0;
        drop_next = '0;
        auto_drop = 1;
        waits = 0; never = 0; spurious = 0;
        cycle();
        cycle();
        wcnt = 0; stb_cycles = 0;
        compare_all("flush");
        rst = 1'b0;
    endtask

    initial begin
        int t, ac, ptr, last;
        logic [N-1:0] mask;

        rst = 1'b1; iReq = '0; iAddress = '0; iData = '0; wb_ack = 1'b0;
        cycle(); cycle(); cycle();
        check("rst_oAck", oAck, 0);
        check("rst_oError", oError, 0);
        check("rst_adr", adr, 0);
        check("rst_dat", dat, 0);
        check("rst_stb", stb, 0);
        check("rst_cyc", cyc, 0);
        check("rst_we", we, 0);
        rst = 1'b0;
        cycle();

        // single request, zero-wait, input changes after grant are ignored
        post(2, 32'h100, {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003});
        iReq = 4'b0100;
        t = cyc_n;
        expect_xfer(2, t, 0, 3, 0, ac);
        cycle(); cycle();
        iAddress[2*32 +: 32] = 32'h5555;
        iData[2*96 +: 96]    = {3{32'hDEADBEEF}};
        wait_acks(1, 20);
        cycle(); cycle(); cycle();
        compare_all("single");

        // all four requesting continuously from reset
        do_reset();
        for (int c = 0; c < N; c++)
            post(c, 32'h1000 * c + 32'h10, {32'h11000000 + 32'(c), 32'h22000000 + 32'(c), 32'h33000000 + 32'(c)});
        auto_drop = 0;
        iReq = 4'b1111;
        t = cyc_n;
        for (int k = 0; k < 5; k++) begin
            expect_xfer(k % N, t, 0, 3, 0, ac);
            t = ac + 1;
        end
        wait_acks(5, 40);
        iReq = '0;
        cycle(); cycle();
        compare_all("rr4");

        // two wait states per word
        do_reset();
        cycle();
        waits = 2;
        post(1, 32'h2000, {32'h01010101, 32'h02020202, 32'h03030303});
        iReq = 4'b0010;
        t = cyc_n;
        expect_xfer(1, t, 2, 3, 0, ac);
        wait_acks(1, 30);
        cycle();
        compare_all("wait2");

        // slave never acknowledges: timeout
        do_reset();
        cycle();
        never = 1;
        stb_cycles = 0;
        post(3, 32'h3000, {32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C});
        iReq = 4'b1000;
        t = cyc_n;
        expect_xfer(3, t, 0, 0, 1, ac);
        wait_acks(1, 30);
        cycle(); cycle();
        check("timeout_stb_cycles", stb_cycles, TO + 1);
        compare_all("timeout");
        never = 0;

        // base address wrap; ACK held high also in IDLE/DONE
        do_reset();
        spurious = 1;
        cycle(); cycle();
        post(0, 32'hFFFFFFFF, {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F});
        iReq = 4'b0001;
        t = cyc_n;
        expect_xfer(0, t, 0, 3, 0, ac);
        wait_acks(1, 20);
        cycle(); cycle(); cycle();
        compare_all("wrap");
        spurious = 0;

        // reset during word 1, then core 0 wins first
        do_reset();
        cycle();
        post(1, 32'h400, {32'h41, 32'h42, 32'h43});
        iReq = 4'b0010;
        t = cyc_n;
        expect_xfer(1, t, 0, 3, 0, ac);
        wait_acks(1, 20);
        cycle();
        compare_all("pre_abort");
        post(0, 32'h500, {32'h51, 32'h52, 32'h53});
        post(2, 32'h600, {32'h61, 32'h62, 32'h63});
        iReq = 4'b0101;
        t = cyc_n;
        expect_xfer(2, t, 0, 2, 0, ac);
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        check("abort_stb", stb, 0);
        check("abort_cyc", cyc, 0);
        check("abort_oAck", oAck, 0);
        check("abort_adr", adr, 0);
        rst = 1'b0;
        t = cyc_n;
        expect_xfer(0, t, 0, 3, 0, ac);
        expect_xfer(2, ac + 1, 0, 3, 0, ac);
        wait_acks(2, 40);
        cycle();
        compare_all("abort");

        // randomized rounds against the round-robin model
        do_reset();
        cycle();
        ptr = 0;
        for (int r = 0; r < 12; r++) begin
            mask     = N'($urandom_range(1, 15));
            waits    = $urandom_range(0, 2);
            spurious = (waits == 0) && ($urandom_range(0, 1) == 1);
            for (int c = 0; c < N; c++)
                if (mask[c]) post(c, $urandom, {$urandom, $urandom, $urandom});
            iReq = mask;
            t = cyc_n;
            last = ptr;
            for (int k = 0; k < N; k++) begin
                if (mask[(ptr + k) % N]) begin
                    expect_xfer((ptr + k) % N, t, waits, 3, 0, ac);
                    t = ac + 1;
                    last = (ptr + k) % N;
                end
            end
            ptr = (last + 1) % N;
            wait_acks($countones(mask), 80);
            cycle();
            compare_all($sformatf("rnd%0d", r));
        end

        check("stray_oError", stray_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
